button_conditioner: RTL and testbench

Single-channel push-button conditioner placed directly downstream of the two-stage D flip-flop synchroniser on each board button. It takes the already-synchronised button level and produces three outputs for the time-setting logic:
- a debounced level;
- one-cycle press and release pulses;
- an auto-repeat pulse train while the button is held.

Instantiate one copy per button.

---
 rtl/button_if.sv | 34 +++
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/button_if.sv
// ============================================================================
// button_if : button conditioner signal bundle (sync'd input, enable, outputs)
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface button_if;
    logic btn_sync;
    logic repeat_en;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_repeat;

    modport master (
        output btn_sync,
        output repeat_en,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_sync,
        input  repeat_en,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : debounce, press/release pulses and auto-repeat
// Revision           : 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int CNT_W         = 26
) (
    input  wire       clk,
    input  wire       rst,
    button_if.slave   btn
);

    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_stable = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_delay  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_period = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_DB_RELEASE = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (btn.btn_sync) begin
                        r_state <= ST_DB_PRESS;
                        r_cnt   <= c_one;
                    end
                end
                ST_DB_PRESS: begin
                    if (!btn.btn_sync) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_stable) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_press  <= 1'b1;
                        r_repeat <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HOLD: begin
                    if (!btn.btn_sync) begin
                        r_state <= ST_DB_RELEASE;
                        r_cnt   <= c_one;
                    end else if (!btn.repeat_en) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == c_delay) begin
                        r_state  <= ST_REPEAT;
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_REPEAT: begin
                    // A release takes priority over a repeat pulse due this edge
                    if (!btn.btn_sync) begin
                        r_state <= ST_DB_RELEASE;
                        r_cnt   <= c_one;
                    end else if (!btn.repeat_en) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_period) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DB_RELEASE: begin
                    // Bounce back to high resumes holding with a fresh repeat delay
                    if (btn.btn_sync) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_stable) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign btn.btn_level   = r_level;
    assign btn.btn_press   = r_press;
    assign btn.btn_release = r_release;
    assign btn.btn_repeat  = r_repeat;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : directed checks of debounce, pulses and auto-repeat
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    button_if bif ();

    button_conditioner #(
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5),
        .CNT_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {level, press, release, repeat}
    logic [3:0] outs;
    assign outs = {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat};

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (lvl,prs,rel,rpt)", tag, got, exp);
        end
    endtask

    // Drive btn_sync, take one edge, then compare outputs 1 time unit later
    task automatic cyc(input logic b, input logic [3:0] exp, input string tag);
        bif.btn_sync = b;
        @(posedge clk);
        #1;
        check(tag, outs, exp);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bif.btn_sync  = 1'b0;
        bif.repeat_en = 1'b1;

        // 1: reset, then clean press
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, $sformatf("t1_reset_%0d", i));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, $sformatf("t1_db_%0d", i));
        cyc(1'b1, 4'b1101, "t1_press");
        cyc(1'b1, 4'b1000, "t1_after_press");
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1000, $sformatf("t1_rel_db_%0d", i));
        cyc(1'b0, 4'b0010, "t1_release");
        cyc(1'b0, 4'b0000, "t1_idle");

        // 2: bounce on press 1,1,1,0,1,1,1,1
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, $sformatf("t2_hi_%0d", i));
        cyc(1'b0, 4'b0000, "t2_bounce");
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, $sformatf("t2_run_%0d", i));
        cyc(1'b1, 4'b1101, "t2_press");

        // 3: auto-repeat at P+10, P+15, P+20, P+25; then disabled
        for (int k = 1; k <= 29; k++)
            cyc(1'b1, (k == 10 || k == 15 || k == 20 || k == 25) ? 4'b1001 : 4'b1000,
                $sformatf("t3_hold_%0d", k));
        bif.repeat_en = 1'b0;
        for (int k = 1; k <= 20; k++) cyc(1'b1, 4'b1000, $sformatf("t3_noen_%0d", k));

        // 4a: release bounce back to HOLD restarts the full repeat delay
        bif.repeat_en = 1'b1;
        cyc(1'b0, 4'b1000, "t4a_lo0");
        cyc(1'b0, 4'b1000, "t4a_lo1");
        cyc(1'b1, 4'b1000, "t4a_back");
        for (int k = 1; k <= 10; k++)
            cyc(1'b1, (k == 10) ? 4'b1001 : 4'b1000, $sformatf("t4a_delay_%0d", k));
        // 4b: bounce 0,0,1,0,0,0,0 from REPEAT
        cyc(1'b0, 4'b1000, "t4b_0");
        cyc(1'b0, 4'b1000, "t4b_1");
        cyc(1'b1, 4'b1000, "t4b_2");
        for (int i = 3; i < 6; i++) cyc(1'b0, 4'b1000, $sformatf("t4b_%0d", i));
        cyc(1'b0, 4'b0010, "t4b_release");
        cyc(1'b0, 4'b0000, "t4b_idle");

        // 5: reset while in REPEAT, button still held
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, $sformatf("t5_db_%0d", i));
        cyc(1'b1, 4'b1101, "t5_press");
        for (int k = 1; k <= 12; k++)
            cyc(1'b1, (k == 10) ? 4'b1001 : 4'b1000, $sformatf("t5_hold_%0d", k));
        rst = 1'b1;
        cyc(1'b1, 4'b0000, "t5_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, $sformatf("t5_redb_%0d", i));
        cyc(1'b1, 4'b1101, "t5_repress");

        // 6: release on the edge a repeat pulse is due
        for (int k = 1; k <= 14; k++)
            cyc(1'b1, (k == 10) ? 4'b1001 : 4'b1000, $sformatf("t6_hold_%0d", k));
        cyc(1'b0, 4'b1000, "t6_drop");
        cyc(1'b0, 4'b1000, "t6_lo1");
        cyc(1'b0, 4'b1000, "t6_lo2");
        cyc(1'b0, 4'b0010, "t6_release");
        cyc(1'b0, 4'b0000, "t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
